// File: rtl/sram_arbiter_pkg.sv
// Shared types and helpers for the CPU/video SRAM arbiter.
package sram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_CPU = 2'd0,
      ST_ARM = 2'd1,
      ST_VID = 2'd2
   } state_e;

   // CPU addresses whose bits [19:6] are all ones are I/O registers, not SRAM
   localparam logic [13:0] IO_PAGE = 14'h3FFF;

   function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// CPU data port, video fetch port and SRAM pins of the arbiter, as one bundle.
interface sram_arbiter_if #(
   parameter int AW = 18
);
   logic [19:0]   cpu_adr;
   logic          cpu_rd;
   logic          cpu_wr;
   logic          cpu_ben;
   logic [31:0]   cpu_wdata;
   logic [31:0]   cpu_rdata;
   logic          cpu_stall;
   logic          vid_req;
   logic [AW-1:0] vid_adr;
   logic          vid_gnt;
   logic          vid_valid;
   logic [31:0]   vid_data;
   logic [AW-1:0] sram_adr;
   logic [31:0]   sram_dout;
   logic [31:0]   sram_din;
   logic          sram_drive;
   logic          sram_we_n;
   logic [3:0]    sram_be_n;

   // master: the arbiter itself; slave: CPU, video engine and SRAM around it
   modport master (
      input  cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata, vid_req, vid_adr, sram_din,
      output cpu_rdata, cpu_stall, vid_gnt, vid_valid, vid_data,
      output sram_adr, sram_dout, sram_drive, sram_we_n, sram_be_n
   );

   modport slave (
      output cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata, vid_req, vid_adr, sram_din,
      input  cpu_rdata, cpu_stall, vid_gnt, vid_valid, vid_data,
      input  sram_adr, sram_dout, sram_drive, sram_we_n, sram_be_n
   );

endinterface

// File: rtl/sram_byte_lane.sv
// Byte-lane steering for CPU accesses: store replication, byte enables, load extract.
module sram_byte_lane
   import sram_arbiter_pkg::*;
(
   input  logic        ben_i,
   input  logic        wr_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] din_i,
   output logic [31:0] dout_o,
   output logic [31:0] rdata_o,
   output logic [3:0]  be_n_o
);

   assign dout_o  = ben_i ? {4{wdata_i[7:0]}} : wdata_i;
   assign rdata_o = ben_i ? {24'b0, lane_sel(din_i, lane_i)} : din_i;

   // Only byte stores narrow the enables; loads always read the full word
   for (genvar gi = 0; gi < 4; gi++) begin : g_be
      assign be_n_o[gi] = ben_i & wr_i & (lane_i != 2'(gi));
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 32-bit SRAM between the RISC5 data port (default owner)
// and fixed-length video read bursts.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int BURST   = 8,
   parameter int MAXWAIT = 15,
   parameter int AW      = 18
) (
   input  logic          clk,
   input  logic          rst,
   sram_arbiter_if.master bus
);

   localparam int BW = $clog2(BURST);
   localparam int WW = $clog2(MAXWAIT + 1);

   state_e        state_q;
   logic [WW-1:0] wait_cnt_q;
   logic [BW-1:0] beat_q;
   logic [AW-1:0] vbase_q;
   logic          stall_q;
   logic          vid_q;

   logic          io;
   logic          mem_acc;
   logic          write_en;
   logic [31:0]   lane_dout;
   logic [31:0]   lane_rdata;
   logic [3:0]    lane_be_n;

   assign io      = (bus.cpu_adr[19:6] == IO_PAGE);
   assign mem_acc = (bus.cpu_rd | bus.cpu_wr) & ~io;

   sram_byte_lane u_lane (
      .ben_i   (bus.cpu_ben),
      .wr_i    (bus.cpu_wr),
      .lane_i  (bus.cpu_adr[1:0]),
      .wdata_i (bus.cpu_wdata),
      .din_i   (bus.sram_din),
      .dout_o  (lane_dout),
      .rdata_o (lane_rdata),
      .be_n_o  (lane_be_n)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_CPU;
         wait_cnt_q <= '0;
         beat_q     <= '0;
         vbase_q    <= '0;
         stall_q    <= 1'b0;
         vid_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_CPU: begin
               if (bus.vid_req && !mem_acc) begin
                  state_q <= ST_VID;
                  vbase_q <= bus.vid_adr;
                  beat_q  <= '0;
                  stall_q <= 1'b1;
                  vid_q   <= 1'b1;
               end else if (bus.vid_req && wait_cnt_q == WW'(MAXWAIT)) begin
                  state_q <= ST_ARM;
                  stall_q <= 1'b1;
               end else if (bus.vid_req) begin
                  if (wait_cnt_q != WW'(MAXWAIT))
                     wait_cnt_q <= wait_cnt_q + 1'b1;
               end else begin
                  wait_cnt_q <= '0;
               end
            end
            // The CPU sees stall this cycle, so the next one is free for video
            ST_ARM: begin
               state_q <= ST_VID;
               vbase_q <= bus.vid_adr;
               beat_q  <= '0;
               vid_q   <= 1'b1;
            end
            ST_VID: begin
               if (beat_q == BW'(BURST - 1)) begin
                  state_q    <= ST_CPU;
                  wait_cnt_q <= '0;
                  beat_q     <= '0;
                  stall_q    <= 1'b0;
                  vid_q      <= 1'b0;
               end else begin
                  beat_q <= beat_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_CPU;
               stall_q <= 1'b0;
               vid_q   <= 1'b0;
            end
         endcase
      end
   end

   // Reset and non-CPU states both keep the write strobe off the pins
   assign write_en = rst & ~stall_q & bus.cpu_wr & ~io;

   assign bus.cpu_stall  = stall_q;
   assign bus.vid_gnt    = vid_q;
   assign bus.vid_valid  = vid_q;
   assign bus.vid_data   = bus.sram_din;
   assign bus.cpu_rdata  = lane_rdata;
   assign bus.sram_adr   = vid_q ? vbase_q + AW'(beat_q) : AW'(bus.cpu_adr[19:2]);
   assign bus.sram_dout  = lane_dout;
   assign bus.sram_we_n  = ~write_en;
   assign bus.sram_drive = write_en;
   assign bus.sram_be_n  = (!rst || (stall_q && !vid_q)) ? 4'b1111 :
                           vid_q ? 4'b0000 : lane_be_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: CPU access vectors plus scoreboarded video bursts.
module tb_sram_arbiter;

   localparam int BURST = 8;

   typedef struct packed {
      logic [17:0] adr;
      logic [31:0] data;
   } beat_t;

   typedef struct {
      logic        rd, wr, ben;
      logic [19:0] adr;
      logic [31:0] wdata;
      logic [17:0] e_adr;
      logic [31:0] e_dout;
      logic [3:0]  e_be_n;
      logic        e_we_n;
      logic [31:0] e_rdata;
      logic        c_rdata;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   beat_t sb_q[$];
   logic [31:0] mem [0:262143];

   sram_arbiter_if #(.AW(18)) bus ();

   sram_arbiter #(.BURST(BURST), .MAXWAIT(15), .AW(18)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int a);
      return (32'(a) * 32'h9E3779B1) ^ 32'h5555AAAA;
   endfunction

   // Behavioural asynchronous SRAM
   initial for (int i = 0; i < 262144; i++) mem[i] <= pat(i);
   assign bus.sram_din = mem[bus.sram_adr];
   always @(posedge clk) begin
      if (rst && !bus.sram_we_n)
         for (int l = 0; l < 4; l++)
            if (!bus.sram_be_n[l]) mem[bus.sram_adr][l*8 +: 8] <= bus.sram_dout[l*8 +: 8];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every video beat must match the next expected address/data
   always @(negedge clk) begin
      if (rst && bus.vid_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: adr %h with empty scoreboard", bus.sram_adr);
         end else begin
            beat_t e;
            e = sb_q.pop_front();
            chk("beat_adr", 32'(bus.sram_adr), 32'(e.adr));
            chk("beat_data", bus.vid_data, e.data);
            chk("beat_stall", 32'(bus.cpu_stall), 32'd1);
         end
      end
   end

   task automatic cpu_idle();
      bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_ben = 1'b0;
      bus.cpu_adr = 20'h0; bus.cpu_wdata = 32'h0;
   endtask

   task automatic push_burst(input logic [17:0] base);
      for (int k = 0; k < BURST; k++) begin
         logic [17:0] a;
         a = base + 18'(k);
         sb_q.push_back('{adr: a, data: mem[a]});
      end
   endtask

   task automatic run_burst(input string name, input logic [17:0] base, input logic c_wr,
                            input logic [19:0] c_adr, input int drop_at, input int e_first_stall,
                            input int e_first_valid, input int e_stalls, input logic e_we0);
      int cyc = 0, first_stall = -1, first_valid = -1, beats = 0, stalls = 0, we_bad = 0;
      logic we0 = 1'b1;
      bit done = 0;
      @(posedge clk); #1;
      push_burst(base);
      bus.vid_adr = base; bus.vid_req = 1'b1;
      bus.cpu_wr = c_wr; bus.cpu_adr = c_adr; bus.cpu_wdata = 32'h0BAD_F00D;
      while (!done && cyc < 100) begin
         @(negedge clk);
         if (cyc == 0) we0 = bus.sram_we_n;
         if (bus.cpu_stall) begin
            stalls++;
            if (first_stall < 0) first_stall = cyc;
            if (!bus.sram_we_n) we_bad++;
         end
         if (bus.vid_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (beats == drop_at) bus.vid_req = 1'b0;
            beats++;
         end else if (beats >= BURST) begin
            done = 1;
         end
         cyc++;
      end
      cpu_idle();
      bus.vid_req = 1'b0;
      chk({name, "_done"}, 32'(done), 32'd1);
      chk({name, "_we0"}, 32'(we0), 32'(e_we0));
      chk({name, "_first_stall"}, 32'(first_stall), 32'(e_first_stall));
      chk({name, "_first_valid"}, 32'(first_valid), 32'(e_first_valid));
      chk({name, "_beats"}, 32'(beats), 32'(BURST));
      chk({name, "_stall_cycles"}, 32'(stalls), 32'(e_stalls));
      chk({name, "_we_in_stall"}, 32'(we_bad), 32'd0);
      chk({name, "_sb_drain"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      $display("burst %s base=%h beats=%0d stalls=%0d first_stall=%0d", name, base, beats, stalls, first_stall);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int beats;
      vecs[0] = '{1'b0, 1'b1, 1'b0, 20'h00104, 32'hDEADBEEF, 18'h41, 32'hDEADBEEF, 4'b0000, 1'b0, 32'h0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 20'h00104, 32'h0, 18'h41, 32'h0, 4'b0000, 1'b1, 32'hDEADBEEF, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 20'h00107, 32'h000000A5, 18'h41, 32'hA5A5A5A5, 4'b0111, 1'b0, 32'h0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 20'h00107, 32'h0, 18'h41, 32'h0, 4'b0000, 1'b1, 32'h000000A5, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 20'h00104, 32'h0, 18'h41, 32'h0, 4'b0000, 1'b1, 32'h000000EF, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 20'h00105, 32'h0000003C, 18'h41, 32'h3C3C3C3C, 4'b1101, 1'b0, 32'h0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 20'h00104, 32'h0, 18'h41, 32'h0, 4'b0000, 1'b1, 32'hA5AD3CEF, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 20'h00106, 32'h0, 18'h41, 32'h0, 4'b0000, 1'b1, 32'h000000AD, 1'b1};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 20'hFFFC0, 32'h12345678, 18'h3FFF0, 32'h12345678, 4'b0000, 1'b1, 32'h0, 1'b0};
      vecs[9] = '{1'b0, 1'b1, 1'b1, 20'hFFFC3, 32'h00000077, 18'h3FFF0, 32'h77777777, 4'b0111, 1'b1, 32'h0, 1'b0};

      // Reset with a store and a video request pending: nothing may reach the pins
      rst = 1'b0;
      bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b1; bus.cpu_ben = 1'b1;
      bus.cpu_adr = 20'h00107; bus.cpu_wdata = 32'h11;
      bus.vid_req = 1'b1; bus.vid_adr = 18'h0;
      repeat (3) @(negedge clk);
      chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
      chk("rst_gnt", 32'(bus.vid_gnt), 32'd0);
      chk("rst_valid", 32'(bus.vid_valid), 32'd0);
      chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rst_drive", 32'(bus.sram_drive), 32'd0);
      chk("rst_be_n", 32'(bus.sram_be_n), 32'hF);
      $display("reset held, outputs idle");
      @(posedge clk); #1;
      cpu_idle();
      bus.vid_req = 1'b0;
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         bus.cpu_rd = vecs[i].rd; bus.cpu_wr = vecs[i].wr; bus.cpu_ben = vecs[i].ben;
         bus.cpu_adr = vecs[i].adr; bus.cpu_wdata = vecs[i].wdata;
         @(negedge clk);
         chk($sformatf("v%0d_adr", i), 32'(bus.sram_adr), 32'(vecs[i].e_adr));
         chk($sformatf("v%0d_dout", i), bus.sram_dout, vecs[i].e_dout);
         chk($sformatf("v%0d_be_n", i), 32'(bus.sram_be_n), 32'(vecs[i].e_be_n));
         chk($sformatf("v%0d_we_n", i), 32'(bus.sram_we_n), 32'(vecs[i].e_we_n));
         chk($sformatf("v%0d_drive", i), 32'(bus.sram_drive), 32'(!vecs[i].e_we_n));
         chk($sformatf("v%0d_stall", i), 32'(bus.cpu_stall), 32'd0);
         if (vecs[i].c_rdata)
            chk($sformatf("v%0d_rdata", i), bus.cpu_rdata, vecs[i].e_rdata);
         $display("cpu vec %0d rd=%b wr=%b ben=%b adr=%h rdata=%h", i, vecs[i].rd, vecs[i].wr,
                  vecs[i].ben, vecs[i].adr, bus.cpu_rdata);
      end
      @(posedge clk); #1;
      cpu_idle();

      // Idle bus, burst wraps past the top of the address space
      run_burst("idle_wrap", 18'h3FFFE, 1'b0, 20'h0, 0, 1, 1, 8, 1'b1);
      // Back-to-back CPU stores: wait counter saturates, then one ARM cycle
      run_burst("contend", 18'h00100, 1'b1, 20'h00300, 0, 16, 17, 9, 1'b0);
      // I/O store does not contend: grant on the next cycle
      run_burst("io_store", 18'h00200, 1'b1, 20'hFFFC0, 0, 1, 1, 8, 1'b1);
      // Request dropped at beat 2 still yields the full burst
      run_burst("drop_b2", 18'h00020, 1'b0, 20'h0, 2, 1, 1, 8, 1'b1);

      // Reset asserted during beat 3
      @(posedge clk); #1;
      push_burst(18'h00050);
      bus.vid_adr = 18'h00050; bus.vid_req = 1'b1;
      beats = 0;
      for (int c = 0; c < 20 && beats < 4; c++) begin
         @(negedge clk);
         if (bus.vid_valid) beats++;
      end
      chk("rstmid_reached_b3", 32'(beats), 32'd4);
      bus.vid_req = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rstmid_stall", 32'(bus.cpu_stall), 32'd0);
      chk("rstmid_valid", 32'(bus.vid_valid), 32'd0);
      chk("rstmid_gnt", 32'(bus.vid_gnt), 32'd0);
      chk("rstmid_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rstmid_left", 32'(sb_q.size()), 32'(BURST - 4));
      sb_q.delete();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rstmid_resume_stall", 32'(bus.cpu_stall), 32'd0);
      chk("rstmid_resume_valid", 32'(bus.vid_valid), 32'd0);
      $display("reset mid-burst after %0d beats", beats);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
